decoder_seq: RTL and testbench
==============================

DECODER_SEQ -- requirements
Module: decoder_seq

Interface
REQ-001 The block SHALL take parameter W, default 4, giving the select width; N = 2**W outputs are derived and not overridable.
REQ-002 The block SHALL take parameter REG_OUT, default 1; 1 = registered decode output, 0 = combinational decode output.
REQ-003 clk  input  1  The block SHALL run on this single clock, rising edge only.
REQ-004 rst  input  1  The block SHALL use this synchronous, active-high reset.
REQ-005 A  input  W  Decode select.
REQ-006 En  input  1  Active-high decode enable.
REQ-007 start  input  1  Single-cycle sweep request.
REQ-008 Y  output  N  One-hot decode output, or all-zero.
REQ-009 busy  output  1  High while a sweep is in progress.
REQ-010 done  output  1  One-cycle pulse on the cycle after the last sweep output.

Function
REQ-011 The block SHALL implement a two-state FSM: IDLE and SWEEP.
REQ-012 In IDLE with REG_OUT=1, the block SHALL drive Y at edge t+1 as bit A set iff En=1 sampled at edge t, else all-zero (1-cycle latency).
REQ-013 In IDLE with REG_OUT=0, Y SHALL equal the combinational decode of A gated by En, with zero latency.
REQ-014 Y SHALL never have more than one bit set, in any state and in either REG_OUT setting.
REQ-015 IDLE -> SWEEP: the block SHALL take this transition on start=1 sampled in IDLE; busy SHALL rise on the following cycle.
REQ-016 In SWEEP, an internal W-bit counter SHALL step 0,1,...,N-1, one value per cycle, and Y SHALL be one-hot at the counter value.
REQ-017 In SWEEP, Y SHALL be registered regardless of REG_OUT; the first sweep cycle SHALL show Y[0]=1.
REQ-018 In SWEEP, the block SHALL ignore A and En entirely; decode requests are dropped, not queued.
REQ-019 In SWEEP, the block SHALL ignore start; there is no restart and no extension of the sweep.
REQ-020 SWEEP -> IDLE: the block SHALL take this transition after the cycle in which Y[N-1]=1.
REQ-021 On that transition cycle, done SHALL be 1 for exactly one cycle, busy SHALL be 0, and Y SHALL be all-zero.
REQ-022 Normal decode SHALL resume on the edge after done.
REQ-023 A sweep SHALL occupy exactly N cycles with busy=1; start-to-done latency SHALL be N+1 cycles.
REQ-024 The sweep counter SHALL stop at N-1 and never wrap back to 0 within a sweep.
REQ-025 If start=1 and En=1 are sampled together in IDLE, start SHALL win: Y SHALL show Y[0] on the next cycle, and the decode of A SHALL be discarded.
REQ-026 With REG_OUT=0 on that same cycle, combinational Y SHALL still reflect A/En, since the FSM is still IDLE.
REQ-027 The W=1 edge case SHALL be legal: N=2, and a sweep lasts 2 cycles.

Reset
REQ-028 While rst=1 at a clock edge, the block SHALL force state=IDLE, counter=0, Y register=0, busy=0, done=0.
REQ-029 Reset SHALL take priority over start, En, and any sweep in progress.
REQ-030 A sweep aborted by reset SHALL NOT produce done.
REQ-031 With REG_OUT=0, Y SHALL follow A/En combinationally even while rst=1; the registered path SHALL read 0.
REQ-032 Outputs SHALL be defined (non-X) from the first edge with rst=1.

Verification
REQ-033 W=2, REG_OUT=1: A=2'b10, En=1 at edge t -> Y=4'b0100 after edge t; En=0 at edge t+1 -> Y=4'b0000.
REQ-034 W=4: pulse start in IDLE -> busy=1 for 16 cycles, Y walks 16'h0001 through 16'h8000 one bit per cycle, then done=1 for one cycle with Y=0 and busy=0.
REQ-035 W=4: start and En=1 (A=4'd7) sampled together -> first post-edge Y=16'h0001, not 16'h0080; a second start mid-sweep -> no effect, done still occurs at cycle 17.
REQ-036 W=3: assert rst at sweep cycle 5 -> next edge Y=0, busy=0, done never pulses; a new start afterwards -> full 8-cycle sweep from Y[0].
REQ-037 W=2, REG_OUT=0: A=2'b11, En=1 in IDLE -> Y=4'b1000 in the same cycle; during a sweep, A/En toggling -> Y still follows the counter.
REQ-038 Every cycle of every test: assert popcount(Y) <= 1; assert done implies !busy.

Source files
------------

// File: rtl/decoder_seq_if.sv
// rtl/decoder_seq_if.sv - decode/sweep request and response bundle for decoder_seq
//
// Purpose: carries the decode select, the enable, the sweep request and the
//          decoder results between a requester (master) and decoder_seq (slave).
// Signals:
//    A      W bits  decode select                  (master -> slave)
//    En     1 bit   active-high decode enable       (master -> slave)
//    start  1 bit   single-cycle sweep request      (master -> slave)
//    Y      N bits  one-hot decode output, or zero  (slave -> master)
//    busy   1 bit   sweep in progress               (slave -> master)
//    done   1 bit   end-of-sweep pulse              (slave -> master)
interface decoder_seq_if #(
   parameter int W = 4
);
   localparam int N = 2**W;

   logic [W-1:0] A;
   logic         En;
   logic         start;
   logic [N-1:0] Y;
   logic         busy;
   logic         done;

   modport master (output A, En, start, input Y, busy, done);
   modport slave  (input A, En, start, output Y, busy, done);
endinterface

// File: rtl/decoder_seq.sv
// rtl/decoder_seq.sv - W-to-2**W one-hot decoder with a self-timed output sweep
//
// Purpose: in IDLE, decodes A gated by En onto Y (registered when REG_OUT=1,
//          combinational when REG_OUT=0). A start request runs a sweep in
//          which Y walks one-hot from bit 0 to bit N-1, one bit per cycle,
//          followed by a one-cycle done pulse with Y cleared.
// Ports:
//    clk   input   rising-edge clock
//    rst   input   synchronous active-high reset
//    bus   slave   decoder_seq_if: A, En, start in; Y, busy, done out
module decoder_seq #(
   parameter int W       = 4,
   parameter bit REG_OUT = 1'b1
) (
   input  logic          clk,
   input  logic          rst,
   decoder_seq_if.slave  bus
);
   localparam int N = 2**W;

   typedef enum logic {IDLE, SWEEP} state_t;

   state_t       r_state, w_state_nxt;
   logic [W-1:0] r_cnt, w_cnt_nxt;
   logic [N-1:0] r_y, w_y_nxt;
   logic         r_done, w_done_nxt;
   logic [N-1:0] w_dec;

   // one-hot decode of A; all-zero when disabled, so Y can never carry two bits
   assign w_dec = bus.En ? ({{(N-1){1'b0}}, 1'b1} << bus.A) : '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_y     <= '0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_y     <= w_y_nxt;
         r_done  <= w_done_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_y_nxt     = r_y;
      w_done_nxt  = 1'b0;
      case (r_state)
         IDLE: begin
            if (bus.start) begin
               // start beats a simultaneous decode: the sweep opens on bit 0
               w_state_nxt = SWEEP;
               w_cnt_nxt   = '0;
               w_y_nxt     = {{(N-1){1'b0}}, 1'b1};
            end else begin
               w_y_nxt = w_dec;
            end
         end
         SWEEP: begin
            // A, En and start are all ignored here; the sweep runs to the end
            if (r_cnt == W'(N-1)) begin
               w_state_nxt = IDLE;
               w_cnt_nxt   = '0;
               w_y_nxt     = '0;
               w_done_nxt  = 1'b1;
            end else begin
               w_cnt_nxt = r_cnt + W'(1);
               w_y_nxt   = r_y << 1;
            end
         end
         default: begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
            w_y_nxt     = '0;
         end
      endcase
   end

   assign bus.busy = (r_state == SWEEP);
   assign bus.done = r_done;

   // The combinational variant still shows the register during a sweep and
   // blanks Y on the done cycle; under reset it follows A/En directly.
   always_comb begin
      if (REG_OUT) begin
         bus.Y = r_y;
      end else if (rst) begin
         bus.Y = w_dec;
      end else if (r_state == SWEEP) begin
         bus.Y = r_y;
      end else if (r_done) begin
         bus.Y = '0;
      end else begin
         bus.Y = w_dec;
      end
   end
endmodule

// File: tb/tb_decoder_seq.sv
// tb/tb_decoder_seq.sv - directed self-checking bench for decoder_seq
module tb_decoder_seq;
   logic clk = 1'b0;
   logic rst;
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   decoder_seq_if #(.W(2)) b2r ();
   decoder_seq_if #(.W(2)) b2c ();
   decoder_seq_if #(.W(4)) b4  ();
   decoder_seq_if #(.W(3)) b3  ();
   decoder_seq_if #(.W(1)) b1  ();

   decoder_seq #(.W(2), .REG_OUT(1'b1)) u2r (.clk(clk), .rst(rst), .bus(b2r));
   decoder_seq #(.W(2), .REG_OUT(1'b0)) u2c (.clk(clk), .rst(rst), .bus(b2c));
   decoder_seq #(.W(4), .REG_OUT(1'b1)) u4  (.clk(clk), .rst(rst), .bus(b4));
   decoder_seq #(.W(3), .REG_OUT(1'b1)) u3  (.clk(clk), .rst(rst), .bus(b3));
   decoder_seq #(.W(1), .REG_OUT(1'b1)) u1  (.clk(clk), .rst(rst), .bus(b1));

   typedef struct {
      logic [1:0] a;
      logic       en;
      logic [3:0] y;
   } vec_t;

   vec_t vecs [7];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic inv(input string name, input logic [31:0] y, input logic busy, input logic done);
      total++;
      if ($countones(y) > 1 || (done && busy)) begin
         bad++;
         $display("FAIL inv_%s: got y=%0h busy=%0b done=%0b want onehot-or-zero and !(done&&busy)",
                  name, y, busy, done);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      inv("2r", 32'(b2r.Y), b2r.busy, b2r.done);
      inv("2c", 32'(b2c.Y), b2c.busy, b2c.done);
      inv("4",  32'(b4.Y),  b4.busy,  b4.done);
      inv("3",  32'(b3.Y),  b3.busy,  b3.done);
      inv("1",  32'(b1.Y),  b1.busy,  b1.done);
   endtask

   initial begin
      vecs[0] = '{2'd2, 1'b1, 4'b0100};
      vecs[1] = '{2'd2, 1'b0, 4'b0000};
      vecs[2] = '{2'd0, 1'b1, 4'b0001};
      vecs[3] = '{2'd1, 1'b1, 4'b0010};
      vecs[4] = '{2'd3, 1'b1, 4'b1000};
      vecs[5] = '{2'd3, 1'b0, 4'b0000};
      vecs[6] = '{2'd1, 1'b0, 4'b0000};

      rst = 1'b1;
      b2r.A = '0; b2r.En = 1'b0; b2r.start = 1'b0;
      b2c.A = '0; b2c.En = 1'b0; b2c.start = 1'b0;
      b4.A  = '0; b4.En  = 1'b0; b4.start  = 1'b0;
      b3.A  = '0; b3.En  = 1'b0; b3.start  = 1'b0;
      b1.A  = '0; b1.En  = 1'b0; b1.start  = 1'b0;

      // reset: comb path follows A/En, registered paths read zero
      b2c.A = 2'd1; b2c.En = 1'b1;
      #1;
      chk("rst_comb_y_pre", 32'(b2c.Y), 32'h2);
      tick();
      chk("rst_comb_y", 32'(b2c.Y), 32'h2);
      chk("rst_2r_y", 32'(b2r.Y), 32'h0);
      chk("rst_4_y", 32'(b4.Y), 32'h0);
      chk("rst_4_busy", 32'(b4.busy), 32'h0);
      chk("rst_4_done", 32'(b4.done), 32'h0);
      chk("rst_3_busy", 32'(b3.busy), 32'h0);
      chk("rst_1_y", 32'(b1.Y), 32'h0);
      b2c.En = 1'b0;
      tick();
      rst = 1'b0;
      tick();

      // idle decode table: comb checked before the edge, registered after it
      for (int i = 0; i < 7; i++) begin
         b2r.A = vecs[i].a; b2r.En = vecs[i].en;
         b2c.A = vecs[i].a; b2c.En = vecs[i].en;
         #1;
         chk($sformatf("comb_vec%0d", i), 32'(b2c.Y), 32'(vecs[i].y));
         tick();
         chk($sformatf("reg_vec%0d", i), 32'(b2r.Y), 32'(vecs[i].y));
      end
      b2r.En = 1'b0; b2c.En = 1'b0;
      tick();

      // W=4 sweep, start together with En (start wins), restart attempt mid-sweep
      b4.start = 1'b1; b4.En = 1'b1; b4.A = 4'd7;
      tick();
      b4.start = 1'b0; b4.En = 1'b0;
      chk("w4_first_y", 32'(b4.Y), 32'h0001);
      chk("w4_first_busy", 32'(b4.busy), 32'h1);
      for (int i = 1; i < 16; i++) begin
         if (i == 5) begin
            b4.start = 1'b1; b4.En = 1'b1; b4.A = 4'd3;
         end else begin
            b4.start = 1'b0; b4.En = 1'b0;
         end
         tick();
         chk($sformatf("w4_y%0d", i), 32'(b4.Y), 32'h1 << i);
         chk($sformatf("w4_busy%0d", i), 32'(b4.busy), 32'h1);
         chk($sformatf("w4_done%0d", i), 32'(b4.done), 32'h0);
      end
      b4.start = 1'b0; b4.En = 1'b0;
      tick();
      chk("w4_done", 32'(b4.done), 32'h1);
      chk("w4_done_busy", 32'(b4.busy), 32'h0);
      chk("w4_done_y", 32'(b4.Y), 32'h0);
      b4.A = 4'd3; b4.En = 1'b1;
      tick();
      chk("w4_after_done", 32'(b4.done), 32'h0);
      chk("w4_resume_y", 32'(b4.Y), 32'h0008);
      b4.En = 1'b0;
      tick();
      chk("w4_idle_y", 32'(b4.Y), 32'h0);

      // W=3 sweep aborted by reset at sweep cycle 5, then a full sweep
      b3.start = 1'b1;
      tick();
      b3.start = 1'b0;
      tick(); tick(); tick(); tick();
      chk("w3_cycle5_y", 32'(b3.Y), 32'h10);
      rst = 1'b1;
      tick();
      chk("w3_abort_y", 32'(b3.Y), 32'h0);
      chk("w3_abort_busy", 32'(b3.busy), 32'h0);
      chk("w3_abort_done", 32'(b3.done), 32'h0);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk($sformatf("w3_nodone%0d", i), 32'(b3.done), 32'h0);
         chk($sformatf("w3_nobusy%0d", i), 32'(b3.busy), 32'h0);
      end
      b3.start = 1'b1;
      tick();
      b3.start = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if (i > 0) tick();
         chk($sformatf("w3_y%0d", i), 32'(b3.Y), 32'h1 << i);
         chk($sformatf("w3_busy%0d", i), 32'(b3.busy), 32'h1);
      end
      tick();
      chk("w3_done", 32'(b3.done), 32'h1);
      chk("w3_done_y", 32'(b3.Y), 32'h0);

      // W=2 combinational: start cycle still shows decode, sweep ignores A/En
      b2c.start = 1'b1; b2c.A = 2'd3; b2c.En = 1'b1;
      #1;
      chk("c2_start_comb", 32'(b2c.Y), 32'h8);
      tick();
      b2c.start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (i > 0) tick();
         b2c.A = 2'(3 - i); b2c.En = (i % 2 == 0);
         #1;
         chk($sformatf("c2_sweep_y%0d", i), 32'(b2c.Y), 32'h1 << i);
         chk($sformatf("c2_sweep_busy%0d", i), 32'(b2c.busy), 32'h1);
      end
      tick();
      b2c.A = 2'd2; b2c.En = 1'b1;
      #1;
      chk("c2_done", 32'(b2c.done), 32'h1);
      chk("c2_done_y", 32'(b2c.Y), 32'h0);
      tick();
      chk("c2_resume_y", 32'(b2c.Y), 32'h4);
      b2c.En = 1'b0;

      // W=1 edge case: two-cycle sweep
      b1.start = 1'b1;
      tick();
      b1.start = 1'b0;
      chk("w1_y0", 32'(b1.Y), 32'h1);
      chk("w1_busy0", 32'(b1.busy), 32'h1);
      tick();
      chk("w1_y1", 32'(b1.Y), 32'h2);
      tick();
      chk("w1_done", 32'(b1.done), 32'h1);
      chk("w1_done_busy", 32'(b1.busy), 32'h0);
      chk("w1_done_y", 32'(b1.Y), 32'h0);
      tick();
      chk("w1_after_done", 32'(b1.done), 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
